// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALUOp/funct into the ALU op code, resolves EX/MEM and MEM/WB
// forwarding, and holds one instruction for issue to the ALU over a valid/ready handshake.
module alu_issue_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // Valid must not depend on ready; in_ready depends only on the held entry and out_ready.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_alusrc,
    input  logic [1:0]       in_aluop,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7_5,
    input  logic             in_regwrite,
    input  logic             in_memread,
    input  logic             in_memwrite,
    input  logic             exmem_regwrite,
    input  logic [4:0]       exmem_rd,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic             memwb_regwrite,
    input  logic [4:0]       memwb_rd,
    input  logic [XLEN-1:0]  memwb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [3:0]       out_op,
    output logic [XLEN-1:0]  out_store_data,
    output logic [4:0]       out_rd,
    output logic             out_regwrite,
    output logic             out_memread,
    output logic             out_memwrite,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    logic             r_valid;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [3:0]       r_op;
    logic [XLEN-1:0]  r_store_data;
    logic [4:0]       r_rd;
    logic             r_regwrite;
    logic             r_memread;
    logic             r_memwrite;
    logic             r_illegal;
    logic [CNT_W-1:0] r_stall;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_stall;
    logic [3:0]       w_op;
    logic             w_illegal;
    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;

    assign w_in_ready = !r_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready && !flush;
    assign w_stall    = in_valid && !w_in_ready && !flush;

    always_comb begin
        w_op      = OP_ADD;
        w_illegal = 1'b0;
        unique case (in_aluop)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                case (in_funct3)
                    3'b000:  w_op = in_funct7_5 ? OP_SUB : OP_ADD;
                    3'b111:  w_op = OP_AND;
                    3'b110:  w_op = OP_OR;
                    3'b010:  w_op = OP_SLT;
                    default: w_illegal = 1'b1;
                endcase
            end
            2'b11: begin
                // I-type has no SUB encoding, so funct7_5 carries no meaning here.
                case (in_funct3)
                    3'b000:  w_op = OP_ADD;
                    3'b111:  w_op = OP_AND;
                    3'b110:  w_op = OP_OR;
                    3'b010:  w_op = OP_SLT;
                    default: w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded.
    always_comb begin
        w_fwd_rs1 = in_rs1_data;
        if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == in_rs1)
            w_fwd_rs1 = exmem_result;
        else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == in_rs1)
            w_fwd_rs1 = memwb_data;
    end

    always_comb begin
        w_fwd_rs2 = in_rs2_data;
        if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == in_rs2)
            w_fwd_rs2 = exmem_result;
        else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == in_rs2)
            w_fwd_rs2 = memwb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= OP_AND;
            r_store_data <= '0;
            r_rd         <= 5'd0;
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_a          <= w_fwd_rs1;
            r_b          <= in_alusrc ? in_imm : w_fwd_rs2;
            r_op         <= w_op;
            r_store_data <= w_fwd_rs2;
            r_rd         <= in_rd;
            r_regwrite   <= in_regwrite && !w_illegal;
            r_memread    <= in_memread;
            r_memwrite   <= in_memwrite;
            r_illegal    <= w_illegal;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall <= '0;
        else if (w_stall && r_stall != {CNT_W{1'b1}})
            r_stall <= r_stall + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = r_valid;
    assign out_a          = r_a;
    assign out_b          = r_b;
    assign out_op         = r_op;
    assign out_store_data = r_store_data;
    assign out_rd         = r_rd;
    assign out_regwrite   = r_regwrite;
    assign out_memread    = r_memread;
    assign out_memwrite   = r_memwrite;
    assign out_illegal    = r_illegal;
    assign stall_count    = r_stall;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, forwarding priority, backpressure, flush,
// illegal encodings, stall counter saturation and asynchronous reset.
module tb_alu_issue_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_rs1, in_rs2, in_rd;
    logic [XLEN-1:0]  in_rs1_data, in_rs2_data, in_imm;
    logic             in_alusrc;
    logic [1:0]       in_aluop;
    logic [2:0]       in_funct3;
    logic             in_funct7_5;
    logic             in_regwrite, in_memread, in_memwrite;
    logic             exmem_regwrite;
    logic [4:0]       exmem_rd;
    logic [XLEN-1:0]  exmem_result;
    logic             memwb_regwrite;
    logic [4:0]       memwb_rd;
    logic [XLEN-1:0]  memwb_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_a, out_b, out_store_data;
    logic [3:0]       out_op;
    logic [4:0]       out_rd;
    logic             out_regwrite, out_memread, out_memwrite, out_illegal;
    logic [CNT_W-1:0] stall_count;

    int n_cmp;
    int n_err;

    alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_alusrc(in_alusrc), .in_aluop(in_aluop),
        .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_regwrite(out_regwrite), .out_memread(out_memread),
        .out_memwrite(out_memwrite), .out_illegal(out_illegal),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
        in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_alusrc = 1'b0;
        in_aluop = 2'b00; in_funct3 = 3'b000; in_funct7_5 = 1'b0;
        in_regwrite = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0;
        exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = '0;
        memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_data = '0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset state
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_op", 64'(out_op), 64'h0);
        chk("rst_stall", 64'(stall_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // R-type SUB, no forwarding
        in_valid = 1'b1; in_aluop = 2'b10; in_funct3 = 3'b000; in_funct7_5 = 1'b1;
        in_rs1 = 5'd1; in_rs2 = 5'd2; in_rs1_data = 64'd10; in_rs2_data = 64'd3;
        in_rd = 5'd7; in_regwrite = 1'b1;
        step();
        in_valid = 1'b0;
        chk("sub_valid", 64'(out_valid), 64'd1);
        chk("sub_op", 64'(out_op), 64'h6);
        chk("sub_a", out_a, 64'd10);
        chk("sub_b", out_b, 64'd3);
        chk("sub_store", out_store_data, 64'd3);
        chk("sub_rd", 64'(out_rd), 64'd7);
        chk("sub_regwrite", 64'(out_regwrite), 64'd1);
        chk("sub_illegal", 64'(out_illegal), 64'd0);
        step();
        chk("sub_drain", 64'(out_valid), 64'd0);

        // Forward priority: EX/MEM wins over MEM/WB; load ADD with immediate
        in_valid = 1'b1; in_aluop = 2'b00; in_funct3 = 3'b011; in_funct7_5 = 1'b0;
        in_rs1 = 5'd5; in_rs2 = 5'd5; in_rs1_data = 64'h11; in_rs2_data = 64'h22;
        in_alusrc = 1'b1; in_imm = 64'h20; in_memread = 1'b1; in_rd = 5'd8;
        exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 64'hAA;
        memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_data = 64'hBB;
        step();
        chk("fwd_ex_a", out_a, 64'hAA);
        chk("fwd_imm_b", out_b, 64'h20);
        chk("fwd_ex_store", out_store_data, 64'hAA);
        chk("ld_op", 64'(out_op), 64'h2);
        chk("ld_memread", 64'(out_memread), 64'd1);

        // Back-to-back: rs1 = x0 never forwards; rs2 falls through to MEM/WB; I-type SLT
        in_aluop = 2'b11; in_funct3 = 3'b010; in_funct7_5 = 1'b1;
        in_rs1 = 5'd0; in_rs1_data = 64'h33; in_alusrc = 1'b0; in_memread = 1'b0;
        exmem_rd = 5'd0;
        step();
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("x0_a", out_a, 64'h33);
        chk("fwd_wb_b", out_b, 64'hBB);
        chk("itype_slt_op", 64'(out_op), 64'h7);

        // Held entry ignores later changes to forward sources
        in_valid = 1'b0; out_ready = 1'b0; memwb_data = 64'hCC; exmem_result = 64'hDD;
        step();
        chk("hold_b", out_b, 64'hBB);
        chk("hold_valid", 64'(out_valid), 64'd1);

        // Backpressure: 3 stalled cycles
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        in_valid = 1'b1; in_aluop = 2'b10; in_funct3 = 3'b111; in_funct7_5 = 1'b0;
        in_rs1 = 5'd3; in_rs2 = 5'd4; in_rs1_data = 64'd5; in_rs2_data = 64'd6; in_rd = 5'd9;
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        step(); step(); step();
        chk("bp_stall3", 64'(stall_count), 64'd3);
        chk("bp_stable_a", out_a, 64'h33);
        chk("bp_stable_op", 64'(out_op), 64'h7);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        step();
        chk("bp_accept_op", 64'(out_op), 64'h0);
        chk("bp_accept_a", out_a, 64'd5);
        chk("bp_accept_b", out_b, 64'd6);
        chk("bp_accept_rd", 64'(out_rd), 64'd9);
        chk("bp_stall_kept", 64'(stall_count), 64'd3);

        // Flush with an entry held and a pending input
        out_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_stall", 64'(stall_count), 64'd3);
        step();
        chk("flush_no_entry", 64'(out_valid), 64'd0);

        // Illegal R-type funct3 001
        out_ready = 1'b1; in_valid = 1'b1; in_aluop = 2'b10; in_funct3 = 3'b001;
        in_regwrite = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ill_flag", 64'(out_illegal), 64'd1);
        chk("ill_op", 64'(out_op), 64'h2);
        chk("ill_regwrite", 64'(out_regwrite), 64'd0);
        chk("ill_valid", 64'(out_valid), 64'd1);

        // Stall counter saturates: 3 + 14 stalled cycles clamps at 15
        out_ready = 1'b0; in_valid = 1'b1; in_funct3 = 3'b110;
        for (int i = 0; i < 14; i++) step();
        chk("stall_sat", 64'(stall_count), 64'd15);

        // Asynchronous reset mid-cycle with an entry held
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_op", 64'(out_op), 64'h0);
        chk("arst_a", out_a, 64'd0);
        chk("arst_illegal", 64'(out_illegal), 64'd0);
        chk("arst_stall", 64'(stall_count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("arst_held_valid", 64'(out_valid), 64'd0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_accept", 64'(out_valid), 64'd1);
        chk("post_rst_op", 64'(out_op), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
